// File: rtl/io_map_pkg.sv
// Shared memory-map definitions for the CPU I/O bridge: peripheral window,
// register addresses, field widths and the default timer prescaler divisor.
package io_map_pkg;

   localparam int DATA_W = 32;
   localparam int LED_W  = 24;
   localparam int SW_W   = 24;
   localparam int BTN_W  = 5;
   localparam int DEB_W  = 16;

   localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;

   localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
   localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
   localparam logic [31:0] ADDR_TDIV  = 32'hFFFF_F024;
   localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
   localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
   localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

   localparam logic [31:0] TIMER_DIV_RST_DEF = 32'd1;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_DIG,
      REG_TIMER,
      REG_TDIV,
      REG_LED,
      REG_SW,
      REG_BTN
   } reg_sel_e;

   // True when the address lies in the 4 KiB peripheral page.
   function automatic logic is_periph(input logic [31:0] addr);
      return addr[31:12] == PERIPH_PAGE;
   endfunction

   // Full-address register decode; memory and unmapped holes give REG_NONE.
   function automatic reg_sel_e decode_reg(input logic [31:0] addr);
      reg_sel_e sel;
      case (addr)
         ADDR_DIG:   sel = REG_DIG;
         ADDR_TIMER: sel = REG_TIMER;
         ADDR_TDIV:  sel = REG_TDIV;
         ADDR_LED:   sel = REG_LED;
         ADDR_SW:    sel = REG_SW;
         ADDR_BTN:   sel = REG_BTN;
         default:    sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: two-flop synchroniser followed by a stability counter.
// The accepted level only follows the synchronised level after it has
// disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
   import io_map_pkg::*;
#(
   parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level
);

   logic [1:0]       sync_q;
   logic [DEB_W-1:0] cnt;

   // Bring the asynchronous button into the clk domain.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], btn_raw};
   end

   // Count consecutive disagreeing cycles; accept the new level at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         btn_level <= 1'b0;
      end else if (sync_q[1] == btn_level) begin
         cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
         btn_level <= sync_q[1];
         cnt       <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/io_bridge.sv
// CPU data-bus bridge: steers stores either to data memory or to the
// peripheral page (display, timer, LEDs) and muxes load data back.
module io_bridge
   import io_map_pkg::*;
#(
   parameter logic [DEB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [DATA_W-1:0] TIMER_DIV_RST   = TIMER_DIV_RST_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       cpu_addr,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   input  logic [31:0]       dram_rdata,
   output logic              dram_we,
   output logic              dig_we,
   output logic [31:0]       dig_wdata,
   output logic [LED_W-1:0]  led,
   input  logic [SW_W-1:0]   sw,
   input  logic [BTN_W-1:0]  btn
);

   reg_sel_e          sel;
   logic              periph;
   logic              st_dig, st_timer, st_tdiv, st_led;
   logic [31:0]       timer, tdiv, presc, div_eff;
   logic              presc_tc;
   logic [SW_W-1:0]   sw_meta, sw_sync;
   logic [BTN_W-1:0]  btn_accepted;

   assign periph   = is_periph(cpu_addr);
   assign sel      = decode_reg(cpu_addr);
   assign dram_we  = cpu_we && !periph;
   assign st_dig   = cpu_we && (sel == REG_DIG);
   assign st_timer = cpu_we && (sel == REG_TIMER);
   assign st_tdiv  = cpu_we && (sel == REG_TDIV);
   assign st_led   = cpu_we && (sel == REG_LED);

   // A divisor of zero counts like a divisor of one.
   assign div_eff  = (tdiv == '0) ? 32'd1 : tdiv;
   assign presc_tc = (presc == div_eff - 32'd1);

   // Load data mux: memory outside the page, register value inside.
   // NOTE: a default is assigned first so no path through always_comb can infer a latch.
   always_comb begin
      cpu_rdata = 32'h0;
      if (!periph) begin
         cpu_rdata = dram_rdata;
      end else begin
         case (sel)
            REG_TIMER: cpu_rdata = timer;
            REG_TDIV:  cpu_rdata = tdiv;
            REG_LED:   cpu_rdata = {{(DATA_W-LED_W){1'b0}}, led};
            REG_SW:    cpu_rdata = {{(DATA_W-SW_W){1'b0}}, sw_sync};
            REG_BTN:   cpu_rdata = {{(DATA_W-BTN_W){1'b0}}, btn_accepted};
            default:   cpu_rdata = 32'h0;
         endcase
      end
   end

   // Display store: capture data and raise a one-cycle strobe after the store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_we    <= 1'b0;
         dig_wdata <= 32'h0;
      end else begin
         dig_we <= st_dig;
         if (st_dig) dig_wdata <= cpu_wdata;
      end
   end

   // LED register, written directly by the store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      led <= '0;
      else if (st_led) led <= cpu_wdata[LED_W-1:0];
   end

   // Prescaled free-running timer; CPU stores override the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= 32'h0;
         presc <= 32'h0;
         tdiv  <= TIMER_DIV_RST;
      end else if (st_timer) begin
         timer <= cpu_wdata;
         presc <= 32'h0;
      end else if (st_tdiv) begin
         tdiv  <= cpu_wdata;
         presc <= 32'h0;
      end else if (presc_tc) begin
         presc <= 32'h0;
         timer <= timer + 32'd1;
      end else begin
         presc <= presc + 32'd1;
      end
   end

   // Two-flop synchroniser for the slide switches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

   for (genvar i = 0; i < BTN_W; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_debounce (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn[i]),
         .btn_level (btn_accepted[i])
      );
   end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000, stable cycles required before a button change is accepted.
REQ-002 Parameter TIMER_DIV_RST, default 32'd1, reset value of the timer prescaler divisor.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_addr  input  32  CPU data-bus byte address.
REQ-006 cpu_we  input  1  CPU store strobe, one cycle per store.
REQ-007 cpu_wdata  input  32  CPU store data.
REQ-008 cpu_rdata  output  32  CPU load data, combinational.
REQ-009 dram_rdata  input  32  data-memory read data.
REQ-010 dram_we  output  1  data-memory write enable.
REQ-011 dig_we  output  1  write strobe to the seven-segment display block.
REQ-012 dig_wdata  output  32  display value, eight hex nibbles, nibble 0 = rightmost digit.
REQ-013 led  output  24  discrete LED drive.
REQ-014 sw  input  24  raw, asynchronous slide switches.
REQ-015 btn  input  5  raw, asynchronous push buttons, active-high.

Function
REQ-016 Peripheral region SHALL be cpu_addr[31:12] == 20'hFFFFF; all other addresses are memory.
REQ-017 Register map (full-address compare): 0xFFFFF000 DIG (W), 0xFFFFF020 TIMER (R/W), 0xFFFFF024 TDIV (R/W), 0xFFFFF060 LED (R/W), 0xFFFFF070 SW (R), 0xFFFFF078 BTN (R).
REQ-018 dram_we SHALL equal cpu_we AND not peripheral region, combinational, zero latency.
REQ-019 cpu_rdata SHALL be dram_rdata outside the region; register value inside; 32'h0 for DIG and unmapped region addresses.
REQ-020 Store to DIG SHALL register dig_wdata <= cpu_wdata and pulse dig_we high for exactly one cycle, on the cycle after the store (latency 1).
REQ-021 dig_wdata SHALL hold its last value between stores; back-to-back stores produce back-to-back pulses with data in order.
REQ-022 Store to LED SHALL update led <= cpu_wdata[23:0] at that clock edge; LED read returns {8'h0, led}.
REQ-023 Stores to SW, BTN or unmapped region addresses SHALL be ignored; no dram_we.
REQ-024 sw SHALL pass a 2-flop synchroniser; SW read returns {8'h0, sw_sync}, 2-cycle input latency.
REQ-025 Each btn bit SHALL pass a 2-flop synchroniser, then its own 16-bit debounce counter: counter clears whenever synced value equals accepted value, otherwise increments; on reaching DEBOUNCE_CYCLES-1 the accepted value takes the synced value and the counter clears.
REQ-026 BTN read returns {27'h0, btn_accepted}; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change btn_accepted.
REQ-027 Timer: 32-bit prescaler counts 0..max(TDIV,1)-1; on terminal count it wraps to 0 and TIMER increments by 1; TDIV = 0 behaves as 1.
REQ-028 TIMER SHALL wrap 32'hFFFFFFFF -> 32'h0 with no flag.
REQ-029 Store to TIMER SHALL load cpu_wdata and clear the prescaler; this wins over a same-cycle increment.
REQ-030 Store to TDIV SHALL load cpu_wdata and clear the prescaler; TIMER unchanged.

Reset
REQ-031 On rst_n low, immediately: dig_we 0, dig_wdata 32'h0, led 24'h0, TIMER 0, prescaler 0, TDIV TIMER_DIV_RST, synchronisers 0, btn_accepted 0, debounce counters 0.
REQ-032 Reset mid-pulse SHALL drop dig_we at once; no pulse is reissued after release.
REQ-033 dram_we and cpu_rdata remain combinational during reset (dram_we follows cpu_we).

Structure
REQ-034 Address constants, field widths and TIMER_DIV_RST default SHALL live in shared package io_map_pkg used also by the CPU top.
REQ-035 Per-button synchroniser plus debounce SHALL be sub-module btn_debounce, instantiated five times; the rest stays flat.

Verification
REQ-036 Store 0x12345678 to 0xFFFFF000 -> next cycle dig_we=1 for one cycle, dig_wdata=0x12345678, dram_we stays 0.
REQ-037 Store 0xAA to 0x00001000 -> dram_we=1 same cycle, dig_we=0, led unchanged.
REQ-038 TDIV=4, TIMER=0xFFFFFFFE, idle 8 cycles -> TIMER reads 0x00000000 (wrapped), one increment per 4 cycles.
REQ-039 btn[2] high for DEBOUNCE_CYCLES-2 cycles then low -> BTN reads 0; held high DEBOUNCE_CYCLES+3 cycles -> BTN reads 0x4.
REQ-040 sw=0x00F00F -> SW reads 0x0000F00F after 2 cycles, 0 before.
REQ-041 Assert rst_n low during dig_we pulse -> dig_we, led, TIMER read 0 immediately; TDIV reads 1 after release.
